pcie_rx_router: RTL and testbench



---
 rtl/pcie_rx_pkg.sv | 22 ++
 rtl/axis_sync_fifo.sv | 70 +++++++
 rtl/pcie_rx_router.sv | 148 ++++++++++++++
 tb/tb_pcie_rx_router.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_rx_pkg.sv
// Shared constants, types and helpers for the PCIe RX router slice.
// The snoop beat layout is {tlast, tkeep, tdata, tuser}, MSB first.
package pcie_rx_pkg;

    localparam int unsigned BAR_HIT_LSB = 2;
    localparam int unsigned BAR_HIT_W   = 7;
    localparam int unsigned TUSER_W     = 22;
    localparam int unsigned DATA_W      = 64;
    localparam int unsigned KEEP_W      = DATA_W / 8;

    typedef struct packed {
        logic              tlast;
        logic [KEEP_W-1:0] tkeep;
        logic [DATA_W-1:0] tdata;
        logic [TUSER_W-1:0] tuser;
    } snoop_beat_t;

    function automatic logic [BAR_HIT_W-1:0] bar_hit(input logic [TUSER_W-1:0] tuser);
        return tuser[BAR_HIT_LSB +: BAR_HIT_W];
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock show-ahead FIFO with an occupancy count; DEPTH must be a power of two.
// The read side follows AXI-Stream: a read happens on rd_valid && rd_ready.
module axis_sync_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     cnt
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             rd_fire;

    assign rd_valid = (cnt_q != '0);
    assign rd_fire  = rd_valid && rd_ready;
    // Empty FIFO presents zeros rather than stale storage.
    assign rd_data  = rd_valid ? mem[rd_ptr_q] : '0;
    assign cnt      = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_en, rd_fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    wr_not_full: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && cnt_q == CntW'(DEPTH)));

endmodule

// File: rtl/pcie_rx_router.sv
// Per-TLP router from the PCIe core RX stream to the PIO engine and a buffered snoop path.
// Routing is decided on the SOF beat from the BAR-hit bits and held through tlast.
module pcie_rx_router
    import pcie_rx_pkg::*;
#(
    parameter int unsigned          C_DATA_WIDTH   = 64,
    parameter int unsigned          KEEP_WIDTH     = C_DATA_WIDTH / 8,
    parameter logic [BAR_HIT_W-1:0] APP_BAR_MASK   = 7'b1101111,
    parameter logic [BAR_HIT_W-1:0] SNOOP_BAR_MASK = 7'b0010000,
    parameter bit                   SNOOP_CPL      = 1'b0,
    parameter int unsigned          SNOOP_DEPTH    = 64,
    parameter int unsigned          MAX_PKT_BEATS  = 34
) (
    input  logic                    user_clk,
    input  logic                    user_reset,
    output logic                    m_axis_rx_tready,
    input  logic                    m_axis_rx_tvalid,
    input  logic                    m_axis_rx_tlast,
    input  logic [KEEP_WIDTH-1:0]   m_axis_rx_tkeep,
    input  logic [C_DATA_WIDTH-1:0] m_axis_rx_tdata,
    input  logic [TUSER_W-1:0]      m_axis_rx_tuser,
    input  logic                    pcie_app_rx_tready,
    output logic                    pcie_app_rx_tvalid,
    output logic                    pcie_app_rx_tlast,
    output logic [KEEP_WIDTH-1:0]   pcie_app_rx_tkeep,
    output logic [C_DATA_WIDTH-1:0] pcie_app_rx_tdata,
    output logic [TUSER_W-1:0]      pcie_app_rx_tuser,
    input  logic                    pcie_snoop_rx_tready,
    output logic                    pcie_snoop_rx_tvalid,
    output logic                    pcie_snoop_rx_tlast,
    output logic [KEEP_WIDTH-1:0]   pcie_snoop_rx_tkeep,
    output logic [C_DATA_WIDTH-1:0] pcie_snoop_rx_tdata,
    output logic [TUSER_W-1:0]      pcie_snoop_rx_tuser,
    input  logic                    snoop_en,
    output logic [31:0]             snoop_drop_cnt
);

    localparam int unsigned SnoopW = 1 + KEEP_WIDTH + C_DATA_WIDTH + TUSER_W;
    localparam int unsigned CntW   = $clog2(SNOOP_DEPTH) + 1;

    logic                    sof_q, sof_d;
    logic                    app_route_q, app_route_d;
    logic                    snoop_route_q, snoop_route_d;
    logic [31:0]             drop_cnt_q, drop_cnt_d;
    logic                    app_vld_q, app_vld_d;
    logic                    app_last_q, app_last_d;
    logic [KEEP_WIDTH-1:0]   app_keep_q, app_keep_d;
    logic [C_DATA_WIDTH-1:0] app_data_q, app_data_d;
    logic [TUSER_W-1:0]      app_user_q, app_user_d;

    logic                 in_fire;
    logic [BAR_HIT_W-1:0] bh;
    logic                 dec_app, dec_want, snoop_room;
    logic                 route_app, route_snoop;
    logic [CntW-1:0]      snoop_cnt;
    logic [SnoopW-1:0]    snoop_rd_data;

    assign m_axis_rx_tready = !app_vld_q || pcie_app_rx_tready;
    assign in_fire          = m_axis_rx_tvalid && m_axis_rx_tready;
    assign bh               = bar_hit(m_axis_rx_tuser);

    always_comb begin
        dec_app    = (bh == '0) || |(bh & APP_BAR_MASK);
        dec_want   = snoop_en && (|(bh & SNOOP_BAR_MASK) || (SNOOP_CPL && bh == '0));
        // Occupancy of this cycle only; a concurrent read is deliberately not credited.
        snoop_room = (32'(SNOOP_DEPTH) - 32'(snoop_cnt)) >= 32'(MAX_PKT_BEATS);
        // On the SOF beat the fresh decode applies directly; later beats use the latch.
        route_app   = sof_q ? dec_app : app_route_q;
        route_snoop = sof_q ? (dec_want && snoop_room) : snoop_route_q;

        sof_d         = sof_q;
        app_route_d   = app_route_q;
        snoop_route_d = snoop_route_q;
        drop_cnt_d    = drop_cnt_q;
        if (in_fire) begin
            sof_d         = m_axis_rx_tlast;
            app_route_d   = route_app;
            snoop_route_d = route_snoop;
            if (sof_q && dec_want && !snoop_room && drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 32'd1;
            end
        end

        app_vld_d  = app_vld_q;
        app_last_d = app_last_q;
        app_keep_d = app_keep_q;
        app_data_d = app_data_q;
        app_user_d = app_user_q;
        if (in_fire && route_app) begin
            app_vld_d  = 1'b1;
            app_last_d = m_axis_rx_tlast;
            app_keep_d = m_axis_rx_tkeep;
            app_data_d = m_axis_rx_tdata;
            app_user_d = m_axis_rx_tuser;
        end else if (pcie_app_rx_tready) begin
            app_vld_d = 1'b0;
        end
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            sof_q         <= 1'b1;
            app_route_q   <= 1'b0;
            snoop_route_q <= 1'b0;
            drop_cnt_q    <= '0;
            app_vld_q     <= 1'b0;
            app_last_q    <= 1'b0;
            app_keep_q    <= '0;
            app_data_q    <= '0;
            app_user_q    <= '0;
        end else begin
            sof_q         <= sof_d;
            app_route_q   <= app_route_d;
            snoop_route_q <= snoop_route_d;
            drop_cnt_q    <= drop_cnt_d;
            app_vld_q     <= app_vld_d;
            app_last_q    <= app_last_d;
            app_keep_q    <= app_keep_d;
            app_data_q    <= app_data_d;
            app_user_q    <= app_user_d;
        end
    end

    assign pcie_app_rx_tvalid = app_vld_q;
    assign pcie_app_rx_tlast  = app_last_q;
    assign pcie_app_rx_tkeep  = app_keep_q;
    assign pcie_app_rx_tdata  = app_data_q;
    assign pcie_app_rx_tuser  = app_user_q;
    assign snoop_drop_cnt     = drop_cnt_q;

    axis_sync_fifo #(
        .DEPTH (SNOOP_DEPTH),
        .WIDTH (SnoopW)
    ) u_snoop_fifo (
        .clk      (user_clk),
        .rst      (user_reset),
        .wr_en    (in_fire && route_snoop),
        .wr_data  ({m_axis_rx_tlast, m_axis_rx_tkeep, m_axis_rx_tdata, m_axis_rx_tuser}),
        .rd_ready (pcie_snoop_rx_tready),
        .rd_valid (pcie_snoop_rx_tvalid),
        .rd_data  (snoop_rd_data),
        .cnt      (snoop_cnt)
    );

    assign {pcie_snoop_rx_tlast, pcie_snoop_rx_tkeep, pcie_snoop_rx_tdata,
            pcie_snoop_rx_tuser} = snoop_rd_data;

endmodule

// File: tb/tb_pcie_rx_router.sv
// Scoreboard bench for pcie_rx_router: the driver queues expected beats per output,
// negedge monitors pop and compare. A second instance runs with SNOOP_CPL=1.
module tb_pcie_rx_router;

    typedef logic [94:0] beat_t; // {tlast, tkeep[7:0], tdata[63:0], tuser[21:0]}

    logic        user_clk = 1'b0;
    logic        user_reset = 1'b1;
    logic        m_tready, m_tready2;
    logic        m_tvalid = 1'b0;
    logic        m_tlast = 1'b0;
    logic [7:0]  m_tkeep = '0;
    logic [63:0] m_tdata = '0;
    logic [21:0] m_tuser = '0;
    logic        app_tready = 1'b1;
    logic        app_tvalid, app_tlast, app_tvalid2, app_tlast2;
    logic [7:0]  app_tkeep, app_tkeep2;
    logic [63:0] app_tdata, app_tdata2;
    logic [21:0] app_tuser, app_tuser2;
    logic        snp_tready = 1'b1;
    logic        snp_tvalid, snp_tlast, snp_tvalid2, snp_tlast2;
    logic [7:0]  snp_tkeep, snp_tkeep2;
    logic [63:0] snp_tdata, snp_tdata2;
    logic [21:0] snp_tuser, snp_tuser2;
    logic        snoop_en = 1'b0;
    logic [31:0] drop_cnt, drop_cnt2;

    int    checks = 0;
    int    errors = 0;
    bit    bp_en = 1'b0;
    beat_t app_q[$];
    beat_t snp_q[$];
    beat_t snp2_q[$];

    pcie_rx_router dut (
        .user_clk             (user_clk),
        .user_reset           (user_reset),
        .m_axis_rx_tready     (m_tready),
        .m_axis_rx_tvalid     (m_tvalid),
        .m_axis_rx_tlast      (m_tlast),
        .m_axis_rx_tkeep      (m_tkeep),
        .m_axis_rx_tdata      (m_tdata),
        .m_axis_rx_tuser      (m_tuser),
        .pcie_app_rx_tready   (app_tready),
        .pcie_app_rx_tvalid   (app_tvalid),
        .pcie_app_rx_tlast    (app_tlast),
        .pcie_app_rx_tkeep    (app_tkeep),
        .pcie_app_rx_tdata    (app_tdata),
        .pcie_app_rx_tuser    (app_tuser),
        .pcie_snoop_rx_tready (snp_tready),
        .pcie_snoop_rx_tvalid (snp_tvalid),
        .pcie_snoop_rx_tlast  (snp_tlast),
        .pcie_snoop_rx_tkeep  (snp_tkeep),
        .pcie_snoop_rx_tdata  (snp_tdata),
        .pcie_snoop_rx_tuser  (snp_tuser),
        .snoop_en             (snoop_en),
        .snoop_drop_cnt       (drop_cnt)
    );

    pcie_rx_router #(
        .SNOOP_CPL (1'b1)
    ) dut_cpl (
        .user_clk             (user_clk),
        .user_reset           (user_reset),
        .m_axis_rx_tready     (m_tready2),
        .m_axis_rx_tvalid     (m_tvalid),
        .m_axis_rx_tlast      (m_tlast),
        .m_axis_rx_tkeep      (m_tkeep),
        .m_axis_rx_tdata      (m_tdata),
        .m_axis_rx_tuser      (m_tuser),
        .pcie_app_rx_tready   (app_tready),
        .pcie_app_rx_tvalid   (app_tvalid2),
        .pcie_app_rx_tlast    (app_tlast2),
        .pcie_app_rx_tkeep    (app_tkeep2),
        .pcie_app_rx_tdata    (app_tdata2),
        .pcie_app_rx_tuser    (app_tuser2),
        .pcie_snoop_rx_tready (1'b1),
        .pcie_snoop_rx_tvalid (snp_tvalid2),
        .pcie_snoop_rx_tlast  (snp_tlast2),
        .pcie_snoop_rx_tkeep  (snp_tkeep2),
        .pcie_snoop_rx_tdata  (snp_tdata2),
        .pcie_snoop_rx_tuser  (snp_tuser2),
        .snoop_en             (snoop_en),
        .snoop_drop_cnt       (drop_cnt2)
    );

    initial forever #5 user_clk = ~user_clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitors: sample at negedge, where a valid&&ready pair means a transfer at the next edge.
    always @(negedge user_clk) begin
        if (!user_reset) begin
            check("in_tready_rule", 128'(m_tready), 128'(!app_tvalid || app_tready));
            check("cpl_inst_tready", 128'(m_tready2), 128'(m_tready));
            check("cpl_inst_app", 128'({app_tvalid2, app_tvalid2 ? {app_tlast2, app_tkeep2,
                app_tdata2, app_tuser2} : 95'd0}), 128'({app_tvalid, app_tvalid ? {app_tlast,
                app_tkeep, app_tdata, app_tuser} : 95'd0}));
            if (app_tvalid && app_tready) begin
                if (app_q.size() == 0) check("app_unexpected", 128'(app_tdata), 128'hx);
                else check("app_beat", 128'({app_tlast, app_tkeep, app_tdata, app_tuser}),
                           128'(app_q.pop_front()));
            end
            if (snp_tvalid && snp_tready) begin
                if (snp_q.size() == 0) check("snoop_unexpected", 128'(snp_tdata), 128'hx);
                else check("snoop_beat", 128'({snp_tlast, snp_tkeep, snp_tdata, snp_tuser}),
                           128'(snp_q.pop_front()));
            end
            if (snp_tvalid2) begin
                if (snp2_q.size() == 0) check("snoop2_unexpected", 128'(snp_tdata2), 128'hx);
                else check("snoop2_beat", 128'({snp_tlast2, snp_tkeep2, snp_tdata2,
                           snp_tuser2}), 128'(snp2_q.pop_front()));
            end
        end
    end

    initial forever begin
        @(posedge user_clk);
        #1;
        if (bp_en) app_tready = ~app_tready;
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic [21:0] u, input bit ea, input bit es, input bit es2,
                             output int st);
        beat_t b;
        b = {l, k, d, u};
        m_tvalid = 1'b1;
        m_tdata  = d;
        m_tkeep  = k;
        m_tlast  = l;
        m_tuser  = u;
        if (ea) app_q.push_back(b);
        if (es) snp_q.push_back(b);
        if (es2) snp2_q.push_back(b);
        st = 0;
        @(negedge user_clk);
        while (!m_tready && st < 200) begin
            st++;
            @(negedge user_clk);
        end
        if (!m_tready) check("input_handshake_timeout", 128'(st), 128'd0);
        @(posedge user_clk);
        #1;
        m_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [6:0] bh, input logic [31:0] seed,
                            input bit ea, input bit es, input bit es2, input int flip_beat,
                            input bit lat, output int stalls);
        int st;
        logic [63:0] d;
        logic [7:0]  k;
        logic [21:0] u;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            if (i == flip_beat) snoop_en = !snoop_en;
            d = {seed, 32'(i)};
            k = (i == n - 1) ? 8'h0F : 8'hFF;
            // Later beats carry inverted BAR bits, which must not reroute the packet.
            u = {13'(seed + 32'(i)), (i == 0) ? bh : ~bh, 2'b10};
            send_beat(d, k, (i == n - 1), u, ea, es, es2, st);
            stalls += st;
            if (lat && i == 0) begin
                check("app_latency_vld", 128'(app_tvalid), 128'd1);
                check("app_latency_data", 128'(app_tdata), 128'(d));
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((app_q.size() + snp_q.size() + snp2_q.size()) != 0 && n < 500) begin
            @(posedge user_clk);
            n++;
        end
        check("drain_left", 128'(app_q.size() + snp_q.size() + snp2_q.size()), 128'd0);
        #1;
    endtask

    initial begin
        int st;
        repeat (3) @(posedge user_clk);
        #1;
        user_reset = 1'b0;
        @(negedge user_clk);
        check("rst_app_vld", 128'(app_tvalid), 128'd0);
        check("rst_snp_vld", 128'(snp_tvalid), 128'd0);
        check("rst_in_rdy", 128'(m_tready), 128'd1);
        check("rst_app_out", 128'({app_tlast, app_tkeep, app_tdata, app_tuser}), 128'd0);
        check("rst_snp_out", 128'({snp_tlast, snp_tkeep, snp_tdata, snp_tuser}), 128'd0);
        check("rst_drop", 128'(drop_cnt), 128'd0);
        @(posedge user_clk);
        #1;

        snoop_en = 1'b1;
        // BAR0 write: app only, 1-cycle latency.
        send_pkt(3, 7'b0000001, 32'hA0A0_0001, 1, 0, 0, -1, 1, st);
        wait_drain();
        // BAR4 write: snoop only.
        send_pkt(3, 7'b0010000, 32'hB4B4_0002, 0, 1, 1, -1, 0, st);
        wait_drain();
        // Completion: app on both instances, snoop only where SNOOP_CPL=1.
        send_pkt(2, 7'b0000000, 32'hC0C0_0003, 1, 0, 1, -1, 0, st);
        wait_drain();

        // Snoop overflow with a stalled snoop consumer.
        snp_tready = 1'b0;
        send_pkt(34, 7'b0010000, 32'hD0D0_0004, 0, 1, 1, -1, 0, st);
        check("ovf_pkt1_stall", 128'(st), 128'd0);
        check("ovf_pkt1_drop", 128'(drop_cnt), 128'd0);
        send_pkt(34, 7'b0010000, 32'hD0D0_0005, 0, 0, 1, -1, 0, st);
        check("ovf_pkt2_stall", 128'(st), 128'd0);
        @(posedge user_clk);
        #1;
        check("ovf_pkt2_drop", 128'(drop_cnt), 128'd1);
        snp_tready = 1'b1;
        wait_drain();
        send_pkt(34, 7'b0010000, 32'hD0D0_0006, 0, 1, 1, -1, 0, st);
        wait_drain();
        check("ovf_pkt3_drop", 128'(drop_cnt), 128'd1);
        check("cpl_inst_drop", 128'(drop_cnt2), 128'd0);

        // App backpressure; snoop_en flips mid-packet must not matter.
        bp_en = 1'b1;
        send_pkt(4, 7'b0010001, 32'hE0E0_0007, 1, 1, 1, 1, 0, st);
        check("bp_stalled", 128'(st > 0), 128'd1);
        send_pkt(4, 7'b0010001, 32'hE0E0_0008, 1, 0, 0, 2, 0, st);
        bp_en = 1'b0;
        @(posedge user_clk);
        #1;
        app_tready = 1'b1;
        wait_drain();

        // Reset on beat 2 of a 4-beat BAR0 packet.
        snoop_en = 1'b0;
        send_beat({32'hF0F0_0009, 32'd0}, 8'hFF, 1'b0, {13'd9, 7'b0000001, 2'b10}, 1, 0, 0, st);
        send_beat({32'hF0F0_0009, 32'd1}, 8'hFF, 1'b0, {13'd10, 7'b1111110, 2'b10}, 1, 0, 0, st);
        user_reset = 1'b1;
        app_q.delete();
        snp_q.delete();
        snp2_q.delete();
        @(negedge user_clk);
        check("mid_rst_app_vld", 128'(app_tvalid), 128'd0);
        check("mid_rst_snp_vld", 128'(snp_tvalid), 128'd0);
        check("mid_rst_drop", 128'(drop_cnt), 128'd0);
        check("mid_rst_in_rdy", 128'(m_tready), 128'd1);
        @(posedge user_clk);
        #1;
        user_reset = 1'b0;
        @(posedge user_clk);
        #1;
        send_pkt(2, 7'b0000001, 32'h1234_000A, 1, 0, 0, -1, 1, st);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
